// File: rtl/vga_text_pkg.sv
// Shared constants, palette and character-word layout for the text-mode pixel pipeline.
package vga_text_pkg;

  localparam int unsigned TXT_PIPE_STAGES  = 3;
  localparam int unsigned GLYPH_W          = 8;
  localparam int unsigned GLYPH_H          = 16;
  localparam int unsigned CURSOR_FIRST_ROW = 14;
  localparam int unsigned RGB_W            = 12;

  // CGA-ordered 16-colour palette, {R,G,B} nibbles
  localparam logic [RGB_W-1:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] code;
  } char_word_t;

endpackage

// File: rtl/vga_text_blink.sv
// Frame counter driven by vsync falling edges; blink_on is high for 16 frames, low for 16.
module vga_text_blink
  import vga_text_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic vsync_i,
  output logic blink_on
);

  localparam int unsigned CNT_W = 5;

  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_nxt_c;
  logic             vs_prev;
  logic             fall_c;

  assign fall_c          = vs_prev & ~vsync_i;
  assign frame_cnt_nxt_c = frame_cnt + CNT_W'(1);

  // Count vsync falls on pixel ticks; blink_on tracks the counter MSB in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
      vs_prev   <= 1'b1;
      blink_on  <= 1'b1;
    end else if (pix_en) begin
      vs_prev <= vsync_i;
      if (fall_c) begin
        frame_cnt <= frame_cnt_nxt_c;
        blink_on  <= ~frame_cnt_nxt_c[CNT_W-1];
      end
    end
  end

endmodule

// File: rtl/vga_text_gen.sv
// Text-mode pixel generator: cell address -> char RAM -> font ROM -> palette RGB, syncs delayed to match.
module vga_text_gen
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned HPOS_WIDTH  = 10,
  parameter int unsigned VPOS_WIDTH  = 10,
  parameter int unsigned CADDR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [HPOS_WIDTH-1:0]  hpos_i,
  input  logic [VPOS_WIDTH-1:0]  vpos_i,
  input  logic                   display_on_i,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  output logic [CADDR_WIDTH-1:0] char_addr,
  input  logic [15:0]            char_data,
  output logic [11:0]            font_addr,
  input  logic [7:0]             font_data,
  input  logic                   cursor_en,
  input  logic [6:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  output logic [RGB_W-1:0]       rgb,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   display_on_o
);

  localparam int unsigned GROW_W = $clog2(GLYPH_H);
  localparam int unsigned BSEL_W = $clog2(GLYPH_W);
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned LAST   = TXT_PIPE_STAGES - 1;

  // Reject configurations whose screen does not fit the character RAM
  if (COLS * ROWS > (2 ** CADDR_WIDTH)) begin : g_cfg_check
    $error("vga_text_gen: COLS*ROWS exceeds character RAM address space");
  end

  logic [COL_W-1:0]       col_c;
  logic [ROW_W-1:0]       row_c;
  logic [CADDR_WIDTH-1:0] addr_c;
  logic                   hit_c;
  char_word_t             word_c;
  logic                   pix_c;
  logic [3:0]             idx_c;
  logic                   blink_on;
  logic                   unused_ok;

  logic [GROW_W-1:0] s0_grow, s1_grow;
  logic [BSEL_W-1:0] s0_bsel, s1_bsel;
  logic              s0_hit, s1_hit;
  logic [3:0]        s1_fg, s1_bg;
  logic [LAST:0]     hs_q, vs_q, de_q;

  assign col_c     = hpos_i[BSEL_W +: COL_W];
  assign row_c     = vpos_i[GROW_W +: ROW_W];
  assign addr_c    = CADDR_WIDTH'(32'(row_c) * COLS + 32'(col_c));
  assign hit_c     = cursor_en & (col_c == cursor_col) & (row_c == cursor_row);
  assign word_c    = char_word_t'(char_data);
  assign pix_c     = font_data[BSEL_W'(GLYPH_W - 1) - s1_bsel]
                   ^ (s1_hit & blink_on & (s1_grow >= GROW_W'(CURSOR_FIRST_ROW)));
  assign idx_c     = pix_c ? s1_fg : s1_bg;
  assign unused_ok = ^{hpos_i[HPOS_WIDTH-1:BSEL_W+COL_W-1], vpos_i[VPOS_WIDTH-1:GROW_W+ROW_W]};

  assign hsync_o      = hs_q[LAST];
  assign vsync_o      = vs_q[LAST];
  assign display_on_o = de_q[LAST];

  vga_text_blink u_blink (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .vsync_i  (vsync_i),
    .blink_on (blink_on)
  );

  // S0: issue character RAM address and latch per-pixel context
  always_ff @(posedge clk) begin
    if (!rst) begin
      char_addr <= '0;
      s0_grow   <= '0;
      s0_bsel   <= '0;
      s0_hit    <= 1'b0;
    end else if (pix_en) begin
      char_addr <= addr_c;
      s0_grow   <= vpos_i[GROW_W-1:0];
      s0_bsel   <= hpos_i[BSEL_W-1:0];
      s0_hit    <= hit_c;
    end
  end

  // S1: capture character word and issue font ROM address
  always_ff @(posedge clk) begin
    if (!rst) begin
      font_addr <= '0;
      s1_grow   <= '0;
      s1_bsel   <= '0;
      s1_hit    <= 1'b0;
      s1_fg     <= '0;
      s1_bg     <= '0;
    end else if (pix_en) begin
      font_addr <= {word_c.code, s0_grow};
      s1_grow   <= s0_grow;
      s1_bsel   <= s0_bsel;
      s1_hit    <= s0_hit;
      s1_fg     <= word_c.fg;
      s1_bg     <= word_c.bg;
    end
  end

  // S2: pick glyph bit, apply cursor, map through palette, blank outside active video
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb <= '0;
    end else if (pix_en) begin
      rgb <= de_q[LAST-1] ? PALETTE[idx_c] : '0;
    end
  end

  // Sync/display delay line matching the three-stage pixel path
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_q <= '1;
      vs_q <= '1;
      de_q <= '0;
    end else if (pix_en) begin
      hs_q <= {hs_q[LAST-1:0], hsync_i};
      vs_q <= {vs_q[LAST-1:0], vsync_i};
      de_q <= {de_q[LAST-1:0], display_on_i};
    end
  end

endmodule

// File: tb/tb_vga_text_gen.sv
// Self-checking bench for vga_text_gen against an arithmetic reference of the text renderer.
module tb_vga_text_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hpos_i, vpos_i;
  logic        display_on_i, hsync_i, vsync_i;
  logic [11:0] char_addr;
  logic [15:0] char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o, display_on_o;

  always #5 clk = ~clk;

  vga_text_gen dut (
    .clk          (clk),
    .rst          (rst),
    .pix_en       (pix_en),
    .hpos_i       (hpos_i),
    .vpos_i       (vpos_i),
    .display_on_i (display_on_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .font_addr    (font_addr),
    .font_data    (font_data),
    .cursor_en    (cursor_en),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row),
    .rgb          (rgb),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .display_on_o (display_on_o)
  );

  // Memories answer within one clock of the address
  logic [15:0] char_ram [4096];
  logic [7:0]  font_rom [4096];
  assign char_data = char_ram[char_addr];
  assign font_data = font_rom[font_addr];

  logic [11:0] pal [16];

  typedef struct {
    int h;
    int v;
    bit de;
    bit hs;
    bit vs;
    bit cen;
    int ccol;
    int crow;
    int fc;
  } samp_t;

  samp_t       q[$];
  int          nt;
  int          fcnt;
  bit          prev_vs;
  logic [38:0] exp_all;
  logic [38:0] obs_all;
  int          ncmp;
  int          nfail;

  assign obs_all = {rgb, hsync_o, vsync_o, display_on_o, char_addr, font_addr};

  function automatic int cell_addr(samp_t s);
    return (((s.v / 16) % 32) * 80 + s.h / 8) % 4096;
  endfunction

  // Expected {rgb, hsync, vsync, display_on} for one sampled pixel, given the frame count in force
  function automatic logic [14:0] ref_video(samp_t s, int fc);
    logic [15:0] w;
    int gr, f, pix;
    w   = char_ram[cell_addr(s)];
    gr  = s.v % 16;
    f   = int'(font_rom[int'(w[7:0]) * 16 + gr]);
    pix = (f >> (7 - (s.h % 8))) & 1;
    if (s.cen && (s.h / 8) == s.ccol && ((s.v / 16) % 32) == s.crow && fc < 16 && gr >= 14)
      pix = pix ^ 1;
    return {s.de ? pal[pix ? w[11:8] : w[15:12]] : 12'h000, s.hs, s.vs, s.de};
  endfunction

  // Advance one clock and update the reference expectation
  task automatic tick(input logic pe);
    samp_t       s;
    logic [14:0] vid;
    logic [11:0] ca, fa;
    pix_en = pe;
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
      nt      = 0;
      fcnt    = 0;
      prev_vs = 1'b1;
      exp_all = {12'h000, 3'b110, 12'h000, 12'h000};
    end else if (pe) begin
      if (prev_vs && !vsync_i) fcnt = (fcnt + 1) % 32;
      prev_vs = vsync_i;
      s.h = int'(hpos_i);  s.v = int'(vpos_i);
      s.de = display_on_i; s.hs = hsync_i; s.vs = vsync_i;
      s.cen = cursor_en;   s.ccol = int'(cursor_col); s.crow = int'(cursor_row);
      s.fc = fcnt;
      q.push_back(s);
      if (q.size() > 3) void'(q.pop_front());
      nt++;
      vid = (nt >= 3) ? ref_video(q[0], q[1].fc) : {12'h000, 3'b110};
      ca  = 12'(cell_addr(q[q.size()-1]));
      if (nt == 1) fa = {char_ram[0][7:0], 4'h0};
      else         fa = {char_ram[cell_addr(q[q.size()-2])][7:0], 4'(q[q.size()-2].v % 16)};
      exp_all = {vid, ca, fa};
    end
  endtask

  task automatic rand_inputs();
    hpos_i       = 10'($urandom_range(0, 799));
    vpos_i       = 10'($urandom_range(0, 524));
    display_on_i = ($urandom % 4) != 0;
    hsync_i      = ($urandom % 10) != 0;
    vsync_i      = ($urandom % 6) != 0;
    cursor_en    = $urandom % 2;
    if ($urandom % 2) begin
      cursor_col = hpos_i[9:3];
      cursor_row = vpos_i[8:4];
    end else begin
      cursor_col = 7'($urandom);
      cursor_row = 5'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(1'b1);
    tick(1'b0);
    ncmp++;
    if (obs_all !== {12'h000, 3'b110, 24'h000000}) begin
      nfail++;
      $display("FAIL reset_state: got %h want %h", obs_all, {12'h000, 3'b110, 24'h000000});
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    hpos_i = '0; vpos_i = '0; display_on_i = 1'b1; hsync_i = 1'b1; vsync_i = 1'b1;
    cursor_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hpos_i = 10'((i < 8) ? i : 7);
      tick(1'b1);
      ncmp++;
      if (obs_all !== exp_all) begin
        nfail++; $display("FAIL basic: got %h want %h", obs_all, exp_all);
      end
      if (i == 2) begin
        ncmp++;
        if (rgb !== 12'hFFF) begin nfail++; $display("FAIL basic_fg: got %h want fff", rgb); end
      end
      if (i == 3) begin
        ncmp++;
        if (rgb !== 12'h00A) begin nfail++; $display("FAIL basic_bg: got %h want 00a", rgb); end
      end
      tick(1'b0);
      ncmp++;
      if (obs_all !== exp_all) begin
        nfail++; $display("FAIL basic_idle: got %h want %h", obs_all, exp_all);
      end
    end
  endtask

  task automatic test_addr();
    logic [15:0] w;
    w = char_ram[162];
    hpos_i = 10'd17; vpos_i = 10'd35;
    tick(1'b1);
    ncmp++;
    if (char_addr !== 12'd162) begin nfail++; $display("FAIL addr_char: got %0d want 162", char_addr); end
    tick(1'b1);
    ncmp++;
    if (font_addr !== {w[7:0], 4'd3}) begin
      nfail++; $display("FAIL addr_font: got %h want %h", font_addr, {w[7:0], 4'd3});
    end
    ncmp++;
    if (obs_all !== exp_all) begin nfail++; $display("FAIL addr: got %h want %h", obs_all, exp_all); end
  endtask

  task automatic test_sync_pulse();
    int out_fall, width;
    out_fall = -1; width = 0;
    display_on_i = 1'b0;
    for (int i = 0; i < 111; i++) begin
      hpos_i  = 10'($urandom_range(0, 639));
      vpos_i  = 10'($urandom_range(0, 479));
      hsync_i = !(i >= 5 && i < 101);
      tick(1'b1);
      ncmp++;
      if (obs_all !== exp_all) begin nfail++; $display("FAIL sync: got %h want %h", obs_all, exp_all); end
      if (i >= 2) begin
        ncmp++;
        if (rgb !== 12'h000) begin nfail++; $display("FAIL blank_rgb: got %h want 000", rgb); end
      end
      if (hsync_o === 1'b0) begin
        width++;
        if (out_fall < 0) out_fall = i;
      end
      tick(1'b0);
      ncmp++;
      if (obs_all !== exp_all) begin nfail++; $display("FAIL sync_idle: got %h want %h", obs_all, exp_all); end
    end
    // Sampled on tick 5, so the third tick (index 7) is where it appears
    ncmp++;
    if (out_fall !== 7) begin nfail++; $display("FAIL sync_delay: got %0d want 7", out_fall); end
    ncmp++;
    if (width !== 96) begin nfail++; $display("FAIL sync_width: got %0d want 96", width); end
    hsync_i = 1'b1;
  endtask

  task automatic test_cursor();
    logic [11:0] want;
    rst = 1'b0; tick(1'b1); rst = 1'b1;
    display_on_i = 1'b1; hsync_i = 1'b1; vsync_i = 1'b1;
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd0; hpos_i = 10'd40;
    for (int phase = 0; phase < 3; phase++) begin
      for (int v = 0; v < 16; v++) begin
        vpos_i = 10'(v);
        repeat (3) begin
          tick(1'b1);
          ncmp++;
          if (obs_all !== exp_all) begin nfail++; $display("FAIL cursor: got %h want %h", obs_all, exp_all); end
        end
        want = (phase != 1 && v >= 14) ? 12'hFFF : 12'h000;
        ncmp++;
        if (rgb !== want) begin
          nfail++; $display("FAIL cursor_row%0d_ph%0d: got %h want %h", v, phase, rgb, want);
        end
      end
      repeat (16) begin
        vsync_i = 1'b0;
        tick(1'b1);
        ncmp++;
        if (obs_all !== exp_all) begin nfail++; $display("FAIL blink: got %h want %h", obs_all, exp_all); end
        vsync_i = 1'b1;
        tick(1'b1);
        ncmp++;
        if (obs_all !== exp_all) begin nfail++; $display("FAIL blink: got %h want %h", obs_all, exp_all); end
      end
    end
  endtask

  task automatic test_pix_en_hold();
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      tick((i >= 20 && i < 30) ? 1'b0 : 1'b1);
      ncmp++;
      if (obs_all !== exp_all) begin nfail++; $display("FAIL hold: got %h want %h", obs_all, exp_all); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      if (i == 400) begin
        rst = 1'b0;
        tick(1'b1);
        ncmp++;
        if ({rgb, hsync_o, vsync_o, display_on_o} !== {12'h000, 3'b110}) begin
          nfail++;
          $display("FAIL mid_reset: got %h want %h", {rgb, hsync_o, vsync_o, display_on_o}, {12'h000, 3'b110});
        end
        rst = 1'b1;
      end else begin
        tick(($urandom % 4) != 0);
        ncmp++;
        if (obs_all !== exp_all) begin nfail++; $display("FAIL random: got %h want %h", obs_all, exp_all); end
      end
    end
  endtask

  initial begin
    ncmp = 0; nfail = 0; nt = 0; fcnt = 0; prev_vs = 1'b1;
    exp_all = '0;
    pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 4096; i++) begin
      char_ram[i] = 16'($urandom);
      font_rom[i] = 8'($urandom);
    end
    char_ram[0]     = 16'h1F41;
    font_rom[12'h410] = 8'h80;
    char_ram[5]     = 16'h0F00;
    for (int r = 0; r < 16; r++) font_rom[r] = 8'h00;

    rst = 1'b0; pix_en = 1'b0;
    hpos_i = '0; vpos_i = '0; display_on_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;

    test_reset();
    test_basic();
    test_addr();
    test_sync_pulse();
    test_cursor();
    test_pix_en_hold();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/vga_text_gen.md
Name: vga_text_gen

Overview:
- Text-mode pixel generator that sits directly downstream of the VGA timing generator.
- Consumes timing outputs: hpos, vpos, display_on, hsync, vsync, and pixel_clk used as a pixel enable.
- Fetches character/attribute words from character RAM and glyph rows from font ROM, then produces 12-bit RGB.
- Sync and display_on are delayed to stay aligned with RGB; the timing generator's mixer-stage parameter is set to TXT_PIPE_STAGES.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, character rows.
- HPOS_WIDTH, 10, width of hpos_i.
- VPOS_WIDTH, 10, width of vpos_i.
- CADDR_WIDTH, 12, character RAM address width; must satisfy COLS*ROWS <= 2**CADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- pix_en  in  1  pixel enable from timing generator (pixel_clk); the pipeline advances only when high.
- hpos_i  in  HPOS_WIDTH  current pixel column.
- vpos_i  in  VPOS_WIDTH  current pixel line.
- display_on_i  in  1  active video.
- hsync_i  in  1  horizontal sync, active-low.
- vsync_i  in  1  vertical sync, active-low.
- char_addr  out  CADDR_WIDTH  character RAM read address.
- char_data  in  16  read data, valid 1 clk after char_addr; [7:0] code, [11:8] fg index, [15:12] bg index.
- font_addr  out  12  font ROM address = {code, glyph_row[3:0]}.
- font_data  in  8  glyph row, valid 1 clk after font_addr; bit 7 is leftmost pixel.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- rgb  out  12  pixel colour {R[3:0], G[3:0], B[3:0]}.
- hsync_o  out  1  delayed hsync_i.
- vsync_o  out  1  delayed vsync_i.
- display_on_o  out  1  delayed display_on_i.

Behaviour:
- Reset (rst==0 at posedge clk): all pipeline registers and the frame counter clear; char_addr=0, font_addr=0, rgb=0, display_on_o=0, hsync_o=1, vsync_o=1 (inactive).
- Every register below updates only on posedge clk with pix_en=1. With pix_en=0, all state and outputs hold.
- S0:
  - col = hpos_i[9:3], row = vpos_i[8:4].
  - char_addr <= row*COLS + col, truncated to CADDR_WIDTH. The multiply is realised as (row<<6)+(row<<4) for COLS=80.
  - Latch glyph_row = vpos_i[3:0], bit_sel = hpos_i[2:0], cursor_hit = cursor_en & (col==cursor_col) & (row==cursor_row), and the three sync/display signals.
- S1: capture char_data; font_addr <= {char_data[7:0], glyph_row}. Carry fg/bg indices, bit_sel, cursor_hit and sync signals forward.
- S2:
  - pix = font_data[7-bit_sel].
  - If cursor_hit & blink_on & glyph_row>=14: pix = ~pix.
  - rgb <= display_on ? PALETTE[pix ? fg : bg] : 12'h000.
  - hsync_o, vsync_o and display_on_o update in the same cycle as rgb.
- Latency: exactly TXT_PIPE_STAGES=3 pix_en ticks from inputs to rgb/sync/display_on_o. Memory data is always sampled at the next pix_en after the address; this is valid for any pix_en duty, including constant 1.
- Blink:
  - 5-bit frame_cnt increments on a vsync_i 1->0 transition, sampled at pix_en; it wraps 31->0.
  - blink_on = ~frame_cnt[4], i.e. 16 frames on, 16 off.
  - blink_on is 1 out of reset.
- When display_on is 0 at S2: rgb=0, regardless of memory data or cursor.
- Addresses computed outside the visible area (hpos>=640, vpos>=480) are still issued; results are masked by display_on. Out-of-range char_addr values must not be prevented.
- Reset asserted mid-frame: the pipeline flushes and outputs return to reset values on the next clk. After release, the first valid rgb appears 3 pix_en ticks later.

Decomposition:
- Package vga_text_pkg holds: TXT_PIPE_STAGES=3; GLYPH_W=8; GLYPH_H=16; CURSOR_FIRST_ROW=14; the 16-entry 12-bit PALETTE constant (CGA ordering: 0=000, 1=00A, 2=0A0, 3=0AA, 4=A00, 5=A0A, 6=A50, 7=AAA, 8=555, 9=55F, A=5F5, B=5FF, C=F55, D=F5F, E=FF5, F=FFF); and a typedef char_word_t packed struct {bg[3:0], fg[3:0], code[7:0]}.
- Sub-module vga_text_blink holds the frame counter and edge detector, outputs blink_on.

Test Plan:
- pix_en every 2nd clk; hpos=0, vpos=0, display_on=1; char_data=16'h1F41; font_data=8'h80 → 3 ticks later rgb=12'hFFF (fg 15); at hpos=1, rgb=12'h00A (bg 1).
- hpos=17, vpos=35 → char_addr=2*80+2=162; font_addr={code,4'd3}.
- display_on_i=0 with font_data=8'hFF → rgb=0. hsync_i pulse of width 96 → hsync_o shows the identical pulse, delayed exactly 3 ticks.
- cursor_en=1, col=5, row=0, font_data=0, fg=F, bg=0, blink_on=1 → glyph rows 14-15 of that cell show FFF, rows 0-13 show 000; after 16 vsync falls → all 000; after 32 falls → FFF again.
- pix_en held 0 for 10 clks mid-line → rgb, sync and addresses frozen; resume without a skipped or duplicated pixel.
- rst=0 for 1 clk mid-frame → next clk rgb=0, hsync_o=vsync_o=1, display_on_o=0, frame_cnt=0.
